uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of byte requesters (2..8).
REQ-002 SHALL have parameter CLK_PER_BIT, default 5208: clock cycles per UART bit (50 MHz / 9600 baud).
REQ-003 SHALL have parameter FRAME_BITS, default 10: bits per frame (start + 8 data + stop).
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req, input, NUM_REQ bits: per-requester byte-valid, held high until that requester's ack.
REQ-007 SHALL have port req_data, input, NUM_REQ*8 bits: byte i at [8i+7:8i], stable while req[i] is high.
REQ-008 SHALL have port ack, output, NUM_REQ bits: one-cycle pulse, one-hot, marking the byte accepted.
REQ-009 SHALL have port tx_data, output, 8 bits: byte for the transmitter, held stable until the next grant.
REQ-010 SHALL have port tx_trig, output, 1 bit: one-cycle start pulse for the transmitter.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in flight.
REQ-012 SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the last granted requester.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-014 IDLE, req==0: SHALL stay in IDLE with all outputs unchanged and ack/tx_trig low.
REQ-015 IDLE, req!=0, at a clock edge: SHALL pick winner w, register tx_data<=req_data[w], tx_trig<=1, ack[w]<=1, grant_id<=w, clear the counter and enter WAIT.
REQ-016 tx_trig and ack SHALL be high exactly one cycle, in the cycle after the sampling edge (latency 1).
REQ-017 WAIT SHALL count WAIT_CYCLES = CLK_PER_BIT*FRAME_BITS cycles and then return to IDLE. req SHALL be ignored in WAIT.
REQ-018 Consecutive tx_trig pulses SHALL be at least WAIT_CYCLES+1 cycles apart, with no gap beyond that while requests are pending.
REQ-019 busy SHALL equal (state==WAIT). It SHALL be high in the same cycle as tx_trig.
REQ-020 Arbitration in round-robin mode: the search SHALL start at ptr, and ptr SHALL become (w+1) mod NUM_REQ after each grant.
REQ-021 A requester dropping req before its ack SHALL lose no other requester's byte. Its own byte is simply not sent.
REQ-022 Counter width SHALL be clog2(WAIT_CYCLES). The counter SHALL never wrap; it is cleared on entry to WAIT.

Reset
REQ-023 RST high SHALL immediately force IDLE and set ack=0, tx_trig=0, tx_data=0, busy=0, grant_id=0, ptr=0 and counter=0.
REQ-024 RST asserted mid-frame SHALL abort the wait. After release, the first grant SHALL follow REQ-015 with ptr=0.

Configuration
REQ-025 Macro UART_TX_ARB_FIXED_PRIO_EN defined: SHALL use fixed priority (lowest index wins) and omit ptr.
REQ-026 Macro undefined: SHALL use round-robin per REQ-020.

Structure
REQ-027 Package uart_pkg SHALL hold the default CLK_PER_BIT and FRAME_BITS values and the FSM state encoding, shared with the uart_rx and uart_tx modules.
REQ-028 The winner selection and ptr SHALL live in a sub-module uart_rr_arb. The FSM, counter and output registers stay in uart_tx_arb.

Verification (CLK_PER_BIT=4, FRAME_BITS=10, NUM_REQ=4, WAIT_CYCLES=40)
REQ-029 The bench SHALL check: req=0001, data0=0x55 -> at cycle +1: tx_trig=1, ack=0001, tx_data=0x55, busy=1. busy then stays high for 40 cycles.
REQ-030 The bench SHALL check: req=1111 held, bytes 0xA0..0xA3, round-robin -> grant order 0,1,2,3,0; trig spacing exactly 41 cycles.
REQ-031 The bench SHALL check: same stimulus with UART_TX_ARB_FIXED_PRIO_EN -> requester 0 regranted every 41 cycles; others starved while req[0]=1.
REQ-032 The bench SHALL check: req[2] rises during WAIT -> no ack until the WAIT ends; the grant comes on the first IDLE edge.
REQ-033 The bench SHALL check: RST pulsed 10 cycles into WAIT -> outputs zero at once; after release with req=0100, grant_id=2 one cycle after the first edge.
REQ-034 The bench SHALL check in every test: ack is one-hot or zero, ack and tx_trig coincide, and tx_data never changes during busy.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, the arbiter FSM state
// encoding and small index helpers used by the TX arbiter and its
// round-robin selector.
package uart_pkg;

  // 50 MHz core clock, 9600 baud
  localparam int CLK_PER_BIT_DEF = 5208;
  // start + 8 data + stop
  localparam int FRAME_BITS_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  // Bits needed to hold 0..n-1; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for 0 <= a,b < n, without a divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Winner selection for the UART TX arbiter.
// Default build: round-robin, search starts at ptr, ptr moves to w+1
// after every grant.
// With UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority (lowest index
// wins) and no pointer state at all.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       grant,
  output logic [$clog2(NUM_REQ)-1:0] win,
  output logic                       any
);

  localparam int ID_W = $clog2(NUM_REQ);

`ifndef UART_TX_ARB_FIXED_PRIO_EN

  logic [ID_W-1:0] ptr;

  // First asserted request at or after ptr, wrapping around
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[wrap_add(int'(ptr), k, NUM_REQ)]) begin
        any = 1'b1;
        win = ID_W'(wrap_add(int'(ptr), k, NUM_REQ));
      end
    end
  end

  // Pointer advances past the winner only when the grant is taken
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        ptr <= '0;
    else if (grant) ptr <= ID_W'(wrap_add(int'(win), 1, NUM_REQ));
  end

`else

  // Lowest asserted index wins; scan downward so the last hit is lowest
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        any = 1'b1;
        win = ID_W'(k);
      end
    end
  end

  // No state in this mode; clock, reset and grant are intentionally unused
  logic unused_ok;
  assign unused_ok = ^{CLK, RST, grant};

`endif

endmodule

// File: rtl/uart_tx_arb.sv
// UART TX byte arbiter: picks one of NUM_REQ byte requesters, hands the
// byte to the transmitter with a one-cycle tx_trig and blocks further
// grants for CLK_PER_BIT*FRAME_BITS cycles while the frame is on the line.
// Optional macro UART_TX_ARB_FIXED_PRIO_EN selects fixed priority instead
// of round-robin (see uart_rr_arb).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_trig,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int WAIT_CYCLES = CLK_PER_BIT * FRAME_BITS;
  localparam int CNT_W       = cnt_width(WAIT_CYCLES);
  localparam int ID_W        = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [7:0]       tx_data_d;
  logic             tx_trig_d;
  logic [ID_W-1:0]  grant_id_d;
  logic [ID_W-1:0]  win;
  logic             any;
  logic             grant;

  uart_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_sel (
    .CLK  (CLK),
    .RST  (RST),
    .req  (req),
    .grant(grant),
    .win  (win),
    .any  (any)
  );

  // Next state and next output values; req is only looked at in IDLE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    tx_trig_d  = 1'b0;
    tx_data_d  = tx_data;
    grant_id_d = grant_id;
    grant      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          grant      = 1'b1;
          state_d    = ST_WAIT;
          cnt_d      = '0;
          ack_d      = NUM_REQ'(1) << win;
          tx_trig_d  = 1'b1;
          tx_data_d  = req_data[{win, 3'b000} +: 8];
          grant_id_d = win;
        end
      end
      ST_WAIT: begin
        // cnt runs 0..WAIT_CYCLES-1, so WAIT lasts exactly WAIT_CYCLES cycles
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ack      <= '0;
      tx_trig  <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack      <= ack_d;
      tx_trig  <= tx_trig_d;
      tx_data  <= tx_data_d;
      grant_id <= grant_id_d;
    end
  end

  assign busy = (state_q == ST_WAIT);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random requester traffic,
// all compared each cycle against a timing/arbitration reference model.
module tb_uart_tx_arb;

  localparam int NR   = 4;
  localparam int CPB  = 4;
  localparam int FB   = 10;
  localparam int WAIT = CPB * FB;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NR-1:0]   req;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   ack;
  logic [7:0]      tx_data;
  logic            tx_trig;
  logic            busy;
  logic [1:0]      grant_id;

  uart_tx_arb #(
    .NUM_REQ    (NR),
    .CLK_PER_BIT(CPB),
    .FRAME_BITS (FB)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .tx_data (tx_data),
    .tx_trig (tx_trig),
    .busy    (busy),
    .grant_id(grant_id)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a grant at edge g blocks edges g+1..g+WAIT, busy is
  // visible after edges g..g+WAIT-1, outputs hold between grants.
  int          e = 0;
  int          g_edge = 0;
  bit          have_g;
  int          rr_ptr;
  logic [7:0]  m_data;
  int          m_gid;
  logic [NR-1:0] m_ack;
  bit          m_trig;
  bit          m_busy;
  bit          prev_busy;
  logic [7:0]  prev_data;
  int          t_edge[$];
  int          t_id[$];

  function automatic int pick(input logic [NR-1:0] r);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (rr_ptr + k) % NR;
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic mreset();
    have_g    = 1'b0;
    rr_ptr    = 0;
    m_data    = 8'h00;
    m_gid     = 0;
    m_ack     = '0;
    m_trig    = 1'b0;
    m_busy    = 1'b0;
    prev_busy = 1'b0;
  endtask

  task automatic compare();
    chk("trig",     {31'b0, tx_trig}, {31'b0, m_trig});
    chk("ack",      {28'b0, ack}, {28'b0, m_ack});
    chk("busy",     {31'b0, busy}, {31'b0, m_busy});
    chk("tx_data",  {24'b0, tx_data}, {24'b0, m_data});
    chk("grant_id", {30'b0, grant_id}, m_gid);
    chk("ack_onehot0", {31'b0, $onehot0(ack)}, 32'd1);
    chk("ack_with_trig", {31'b0, |ack}, {31'b0, tx_trig});
    if (prev_busy && busy) chk("data_stable", {24'b0, tx_data}, {24'b0, prev_data});
    prev_busy = busy;
    prev_data = tx_data;
    if (tx_trig) begin
      t_edge.push_back(e);
      t_id.push_back(int'(grant_id));
    end
  endtask

  // One clock: model reacts to the sampled inputs, then outputs are checked
  task automatic step();
    logic [NR-1:0] r;
    @(posedge CLK);
    r = req;
    e++;
    m_trig = 1'b0;
    m_ack  = '0;
    if (RST) mreset();
    else if (r != '0 && (!have_g || e >= g_edge + WAIT + 1)) begin
      int w;
      w = pick(r);
      m_trig    = 1'b1;
      m_ack[w]  = 1'b1;
      m_data    = req_data[w*8 +: 8];
      m_gid     = w;
      g_edge    = e;
      have_g    = 1'b1;
      rr_ptr    = (w + 1) % NR;
    end
    m_busy = !RST && have_g && e >= g_edge && e <= g_edge + WAIT - 1;
    #1;
    compare();
  endtask

  task automatic steps(input int n, input bit drop_on_ack);
    for (int k = 0; k < n; k++) begin
      step();
      if (drop_on_ack) req = req & ~m_ack;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    mreset();
    steps(2, 1'b0);
    RST = 1'b0;
  endtask

  initial begin
    int nb;
    RST = 1'b1;
    req = '0;
    req_data = '0;
    mreset();
    #12;
    chk("rst_trig", {31'b0, tx_trig}, 32'd0);
    chk("rst_ack",  {28'b0, ack}, 32'd0);
    chk("rst_data", {24'b0, tx_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_gid",  {30'b0, grant_id}, 32'd0);
    RST = 1'b0;

    // single byte, latency and frame length
    req = 4'b0001;
    req_data[7:0] = 8'h55;
    step();
    chk("t1_trig", {31'b0, tx_trig}, 32'd1);
    chk("t1_ack",  {28'b0, ack}, 32'b0001);
    chk("t1_data", {24'b0, tx_data}, 32'h55);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    req = req & ~m_ack;
    nb = 1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (busy) nb++;
    end
    chk("t1_busy_len", nb, WAIT);

    // all four held: grant order and spacing
    do_reset();
    req = 4'hF;
    req_data = 32'hA3A2A1A0;
    t_edge.delete();
    t_id.delete();
    steps(5 * (WAIT + 1) + 2, 1'b0);
    chk("t2_count", (t_id.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    if (t_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        chk("t2_order", t_id[k], 0);
`else
        chk("t2_order", t_id[k], k % NR);
`endif
        if (k < 4) chk("t2_spacing", t_edge[k+1] - t_edge[k], WAIT + 1);
      end
    end

    // request arriving mid-frame waits for the first IDLE edge
    req = '0;
    steps(WAIT + 5, 1'b1);
    t_edge.delete();
    t_id.delete();
    req = 4'b0001;
    req_data[7:0] = 8'h11;
    steps(10, 1'b1);
    req[2] = 1'b1;
    req_data[23:16] = 8'h77;
    steps(WAIT + 10, 1'b1);
    chk("t3_count", (t_id.size() == 2) ? 32'd1 : 32'd0, 32'd1);
    if (t_id.size() == 2) begin
      chk("t3_id", t_id[1], 2);
      chk("t3_spacing", t_edge[1] - t_edge[0], WAIT + 1);
    end

    // reset mid-frame aborts the wait, first grant afterwards follows ptr=0
    req = '0;
    steps(WAIT + 5, 1'b1);
    req = 4'b0001;
    req_data[7:0] = 8'h99;
    steps(11, 1'b1);
    RST = 1'b1;
    #1;
    chk("t4_trig", {31'b0, tx_trig}, 32'd0);
    chk("t4_ack",  {28'b0, ack}, 32'd0);
    chk("t4_data", {24'b0, tx_data}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_gid",  {30'b0, grant_id}, 32'd0);
    mreset();
    steps(2, 1'b0);
    RST = 1'b0;
    req = 4'b0100;
    req_data[23:16] = 8'h3C;
    step();
    chk("t4_gid_after", {30'b0, grant_id}, 32'd2);
    chk("t4_trig_after", {31'b0, tx_trig}, 32'd1);
    req = req & ~m_ack;

    // random traffic: requesters join, get served or give up
    steps(WAIT + 5, 1'b1);
    for (int n = 0; n < 2000; n++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (req[i] && m_ack[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(15) == 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
